// File: rtl/mem_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : Memory-access pipeline stage of the 5-stage MIPS core.
//               Registers the execute payload, holds synchronous SRAM read
//               data across writeback stalls, extracts load results
//               (LW/LH/LHU/LB/LBU/LWL/LWR) and carries exception/CP0 fields
//               through to writeback.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 123,
    parameter int MS_TO_WS_BUS_WD = 83
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic [31:0]                data_sram_rdata,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic                       ms_to_es_bus,
    output logic [31:0]                ms_forward,
    output logic [6:0]                 ms_to_ds_addr,
    input  logic                       ex_from_ws
);

    logic                       r_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] r_es_bus;
    logic                       r_first_cycle;
    logic                       r_rbuf_v;
    logic [31:0]                r_rbuf;

    logic        w_accept;
    logic        w_flush;
    logic [31:0] w_rdata_eff;

    // Decoded fields of the registered execute payload
    logic        w_mtc0_we;
    logic [4:0]  w_cp0_addr;
    logic        w_ex;
    logic [4:0]  w_excode;
    logic        w_res_from_cp0;
    logic        w_lwl;
    logic        w_lwr;
    logic [31:0] w_rt_value;
    logic        w_ld_w;
    logic        w_ld_h;
    logic        w_ld_b;
    logic        w_ld_sign;
    logic [1:0]  w_addr_lo;
    logic        w_gr_we;
    logic [4:0]  w_dest;
    logic [31:0] w_alu_result;
    logic [31:0] w_pc;

    logic [15:0] w_half;
    logic [7:0]  w_byte;
    logic [31:0] w_lwl_data;
    logic [31:0] w_lwr_data;
    logic [31:0] w_final_result;
    logic        w_gr_we_out;
    logic        w_is_load;

    assign {w_mtc0_we, w_cp0_addr, w_ex, w_excode, w_res_from_cp0,
            w_lwl, w_lwr, w_rt_value,
            w_ld_w, w_ld_h, w_ld_b, w_ld_sign, w_addr_lo,
            w_gr_we, w_dest, w_alu_result, w_pc} = r_es_bus;

    // Handshake: this stage always completes in one cycle
    assign ms_allowin     = ~r_ms_valid | ws_allowin;
    assign ms_to_ws_valid = r_ms_valid;
    assign w_accept       = es_to_ms_valid & ms_allowin;
    assign w_flush        = reset | ex_from_ws;

    // Valid bit: a flush kills both the occupant and any instruction arriving
    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            r_ms_valid <= es_to_ms_valid;
        end
    end

    // Payload register, loaded only on a real accept
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_es_bus <= es_to_ms_bus;
        end
    end

    // SRAM data is only valid in the first cycle; keep a copy if writeback stalls
    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_first_cycle <= 1'b0;
            r_rbuf_v      <= 1'b0;
        end else begin
            r_first_cycle <= w_accept;
            if (w_accept) begin
                r_rbuf_v <= 1'b0;
            end else if (r_ms_valid && r_first_cycle && !ws_allowin) begin
                r_rbuf_v <= 1'b1;
                r_rbuf   <= data_sram_rdata;
            end
        end
    end

    assign w_rdata_eff = r_rbuf_v ? r_rbuf : data_sram_rdata;

    // Sub-word selection and unaligned-load merging
    always_comb begin
        w_half = w_addr_lo[1] ? w_rdata_eff[31:16] : w_rdata_eff[15:0];
        case (w_addr_lo)
            2'd0:    w_byte = w_rdata_eff[7:0];
            2'd1:    w_byte = w_rdata_eff[15:8];
            2'd2:    w_byte = w_rdata_eff[23:16];
            default: w_byte = w_rdata_eff[31:24];
        endcase
        case (w_addr_lo)
            2'd0:    w_lwl_data = {w_rdata_eff[7:0],  w_rt_value[23:0]};
            2'd1:    w_lwl_data = {w_rdata_eff[15:0], w_rt_value[15:0]};
            2'd2:    w_lwl_data = {w_rdata_eff[23:0], w_rt_value[7:0]};
            default: w_lwl_data = w_rdata_eff;
        endcase
        case (w_addr_lo)
            2'd0:    w_lwr_data = w_rdata_eff;
            2'd1:    w_lwr_data = {w_rt_value[31:24], w_rdata_eff[31:8]};
            2'd2:    w_lwr_data = {w_rt_value[31:16], w_rdata_eff[31:16]};
            default: w_lwr_data = {w_rt_value[31:8],  w_rdata_eff[31:24]};
        endcase
    end

    // Result mux; an excepting instruction passes its address through for BadVAddr
    always_comb begin
        w_final_result = w_alu_result;
        if (!w_ex) begin
            if (w_ld_w) begin
                w_final_result = w_rdata_eff;
            end else if (w_ld_h) begin
                w_final_result = {{16{w_ld_sign & w_half[15]}}, w_half};
            end else if (w_ld_b) begin
                w_final_result = {{24{w_ld_sign & w_byte[7]}}, w_byte};
            end else if (w_lwl) begin
                w_final_result = w_lwl_data;
            end else if (w_lwr) begin
                w_final_result = w_lwr_data;
            end
        end
    end

    assign w_gr_we_out = w_gr_we & ~w_ex;
    assign w_is_load   = w_ld_w | w_ld_h | w_ld_b | w_lwl | w_lwr;

    assign ms_to_ws_bus  = {w_mtc0_we, w_cp0_addr, w_ex, w_excode, w_res_from_cp0,
                            w_gr_we_out, w_dest, w_final_result, w_pc};
    assign ms_to_es_bus  = r_ms_valid & w_ex;
    assign ms_forward    = w_final_result;
    assign ms_to_ds_addr = {r_ms_valid & w_gr_we_out, w_is_load, w_dest};

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Scoreboard bench for mem_stage. The driver pushes the
//               expected writeback payload when an instruction is accepted;
//               a monitor compares every cycle the stage presents valid data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    logic         clk;
    logic         reset;
    logic         ws_allowin;
    logic         ms_allowin;
    logic         es_to_ms_valid;
    logic [122:0] es_to_ms_bus;
    logic [31:0]  data_sram_rdata;
    logic         ms_to_ws_valid;
    logic [82:0]  ms_to_ws_bus;
    logic         ms_to_es_bus;
    logic [31:0]  ms_forward;
    logic [6:0]   ms_to_ds_addr;
    logic         ex_from_ws;

    mem_stage #(.ES_TO_MS_BUS_WD(123), .MS_TO_WS_BUS_WD(83)) dut (
        .clk             (clk),
        .reset           (reset),
        .ws_allowin      (ws_allowin),
        .ms_allowin      (ms_allowin),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .data_sram_rdata (data_sram_rdata),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_to_ws_bus    (ms_to_ws_bus),
        .ms_to_es_bus    (ms_to_es_bus),
        .ms_forward      (ms_forward),
        .ms_to_ds_addr   (ms_to_ds_addr),
        .ex_from_ws      (ex_from_ws)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [82:0] bus;
        logic [6:0]  ds;
        logic        es;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_err    = 0;
    logic [31:0] next_rd;
    bit          next_rd_v = 0;

    localparam int K_NONE = 0, K_W = 1, K_H = 2, K_B = 3, K_LWL = 4, K_LWR = 5;

    task automatic chk(input string nm, input logic [82:0] act, input logic [82:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Build an execute payload from instruction-level fields
    function automatic logic [122:0] mk(input bit ex, input logic [4:0] excode, input int kind,
                                        input bit sgn, input logic [1:0] a, input logic [31:0] rt,
                                        input logic [31:0] alu, input logic [31:0] pc,
                                        input logic [4:0] dest, input bit gr_we,
                                        input bit mtc0, input logic [4:0] cp0, input bit rfc);
        logic [122:0] b;
        b = '0;
        b[122] = mtc0; b[121:117] = cp0; b[116] = ex; b[115:111] = excode; b[110] = rfc;
        b[109] = (kind == K_LWL); b[108] = (kind == K_LWR); b[107:76] = rt;
        b[75] = (kind == K_W); b[74] = (kind == K_H); b[73] = (kind == K_B);
        b[72] = sgn; b[71:70] = a;
        b[69] = gr_we; b[68:64] = dest; b[63:32] = alu; b[31:0] = pc;
        return b;
    endfunction

    // Reference load semantics expressed as byte shifts and masks
    function automatic logic [31:0] ref_result(input logic [122:0] b, input logic [31:0] rd);
        logic [31:0] rt;
        logic [31:0] alu;
        logic [31:0] v;
        int          a;
        rt  = b[107:76];
        alu = b[63:32];
        a   = int'(b[71:70]);
        if (b[116]) return alu;
        if (b[75])  return rd;
        if (b[74]) begin
            v = (rd >> (16 * (a / 2))) & 32'h0000FFFF;
            if (b[72] && v[15]) v = v | 32'hFFFF0000;
            return v;
        end
        if (b[73]) begin
            v = (rd >> (8 * a)) & 32'h000000FF;
            if (b[72] && v[7]) v = v | 32'hFFFFFF00;
            return v;
        end
        if (b[109]) return (rd << (8 * (3 - a))) | (rt & ~(32'hFFFFFFFF << (8 * (3 - a))));
        if (b[108]) return (rd >> (8 * a)) | (rt & ~(32'hFFFFFFFF >> (8 * a)));
        return alu;
    endfunction

    function automatic exp_t model(input logic [122:0] b, input logic [31:0] rd);
        exp_t e;
        bit   we;
        bit   ld;
        we    = b[69] & ~b[116];
        ld    = b[75] | b[74] | b[73] | b[109] | b[108];
        e.bus = {b[122:110], we, b[68:64], ref_result(b, rd), b[31:0]};
        e.ds  = {we, ld, b[68:64]};
        e.es  = b[116];
        return e;
    endfunction

    // One driver cycle; rd is the SRAM word this instruction will see
    task automatic drive(input bit v, input logic [122:0] b, input logic [31:0] rd,
                         input bit ws, input bit fl);
        bit acc;
        @(negedge clk);
        ws_allowin      = ws;
        ex_from_ws      = fl;
        data_sram_rdata = next_rd_v ? next_rd : $urandom;
        next_rd_v       = 0;
        es_to_ms_valid  = v;
        es_to_ms_bus    = b;
        acc = v && ((q.size() == 0) || ws) && !fl;
        if (acc) begin
            @(posedge clk);
            #1;
            q.push_back(model(b, rd));
            next_rd   = rd;
            next_rd_v = 1;
        end
    endtask

    task automatic idle(input bit ws);
        drive(0, '0, 32'h0, ws, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset          = 1'b1;
        es_to_ms_valid = 1'b0;
        ex_from_ws     = 1'b0;
        @(posedge clk);
        #1;
        q.delete();
        next_rd_v = 0;
        reset     = 1'b0;
    endtask

    // Monitor: compare whatever the stage presents against the scoreboard head
    always begin
        @(negedge clk);
        #2;
        if (!reset) begin
            chk("ms_allowin", 83'(ms_allowin), 83'((q.size() == 0) || ws_allowin));
            chk("ms_to_ws_valid", 83'(ms_to_ws_valid), 83'(q.size() != 0));
            if (ms_to_ws_valid && q.size() != 0) begin
                chk("ms_to_ws_bus", ms_to_ws_bus, q[0].bus);
                chk("ms_forward", 83'(ms_forward), 83'(q[0].bus[63:32]));
                chk("ms_to_ds_addr", 83'(ms_to_ds_addr), 83'(q[0].ds));
                chk("ms_to_es_bus", 83'(ms_to_es_bus), 83'(q[0].es));
            end
            if (q.size() != 0 && (ex_from_ws || ws_allowin)) void'(q.pop_front());
        end
    end

    initial begin
        reset           = 1'b1;
        ws_allowin      = 1'b1;
        es_to_ms_valid  = 1'b0;
        es_to_ms_bus    = '0;
        data_sram_rdata = '0;
        ex_from_ws      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1);

        // LB signed / unsigned, byte 3
        drive(1, mk(0, 5'd0, K_B, 1, 2'd3, 32'h0, 32'h103, 32'hBFC00000, 5'd4, 1, 0, 5'd0, 0), 32'h80FF1234, 1, 0);
        drive(1, mk(0, 5'd0, K_B, 0, 2'd3, 32'h0, 32'h103, 32'hBFC00004, 5'd5, 1, 0, 5'd0, 0), 32'h80FF1234, 1, 0);
        // LWL a=1, LWR a=2
        drive(1, mk(0, 5'd0, K_LWL, 0, 2'd1, 32'hAABBCCDD, 32'h201, 32'hBFC00008, 5'd6, 1, 0, 5'd0, 0), 32'h11223344, 1, 0);
        drive(1, mk(0, 5'd0, K_LWR, 0, 2'd2, 32'hAABBCCDD, 32'h202, 32'hBFC0000C, 5'd7, 1, 0, 5'd0, 0), 32'h11223344, 1, 0);
        idle(1);
        // LW held across a 3-cycle writeback stall
        drive(1, mk(0, 5'd0, K_W, 0, 2'd0, 32'h0, 32'h300, 32'hBFC00010, 5'd8, 1, 0, 5'd0, 0), 32'hDEADBEEF, 0, 0);
        repeat (3) idle(0);
        idle(1);
        // Address-error exception passes alu_result through
        drive(1, mk(1, 5'h04, K_W, 0, 2'd3, 32'h0, 32'h1003, 32'hBFC00014, 5'd9, 1, 0, 5'd0, 0), 32'h55555555, 1, 0);
        idle(1);
        // Flush collides with accept: nothing enters
        drive(1, mk(0, 5'd0, K_W, 0, 2'd0, 32'h0, 32'h400, 32'hBFC00018, 5'd10, 1, 0, 5'd0, 0), 32'h12345678, 1, 1);
        idle(1);
        // Back-to-back LH then ALU op
        drive(1, mk(0, 5'd0, K_H, 1, 2'd2, 32'h0, 32'h502, 32'hBFC0001C, 5'd11, 1, 0, 5'd0, 0), 32'h7FFF0000, 1, 0);
        drive(1, mk(0, 5'd0, K_NONE, 0, 2'd0, 32'h0, 32'h5, 32'hBFC00020, 5'd12, 1, 0, 5'd0, 0), 32'h0, 1, 0);
        idle(1);
        // Reset in the middle of a stalled load, then a fresh stalled load
        drive(1, mk(0, 5'd0, K_W, 0, 2'd0, 32'h0, 32'h600, 32'hBFC00024, 5'd13, 1, 0, 5'd0, 0), 32'hCAFEF00D, 0, 0);
        idle(0);
        do_reset();
        drive(1, mk(0, 5'd0, K_W, 0, 2'd0, 32'h0, 32'h700, 32'hBFC00028, 5'd14, 1, 0, 5'd0, 0), 32'h0BADC0DE, 1, 0);
        repeat (2) idle(0);
        idle(1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            int          kind;
            bit          ex;
            logic [31:0] rd;
            kind = int'($urandom_range(0, 5));
            ex   = ($urandom_range(0, 9) == 0);
            rd   = $urandom;
            drive($urandom_range(0, 9) < 7,
                  mk(ex, 5'($urandom), kind, 1'($urandom), 2'($urandom), $urandom, $urandom, $urandom,
                     5'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), 1'($urandom)),
                  rd, $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
        end
        idle(1);
        idle(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
